// File: rtl/ftdi_pkg.sv
// Shared FTDI 245 synchronous FIFO definitions: bus width, pin levels, FSM states.
package ftdi_pkg;

  localparam int unsigned FTDI_BYTE_W = 8;

  // FTDI control pins are active-low.
  localparam logic FTDI_ASSERTED   = 1'b0;
  localparam logic FTDI_DEASSERTED = 1'b1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    OE_SETUP = 2'd1,
    READ     = 2'd2,
    RELEASE  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/byte_fifo.sv
// Synchronous first-word-fall-through byte FIFO with a registered head and valid flag.
module byte_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);
  localparam logic [AW:0]   CNT_ONE    = (AW + 1)'(1);
  localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             empty_q, empty_d;
  logic             full;
  logic             push_ok;
  logic             pop_ok;

  assign full        = (count_q == FULL_COUNT);
  assign full_o      = full;
  assign empty_o     = empty_q;
  assign count_o     = count_q;
  assign head_data_o = head_q;

  // Next pointers, occupancy and head word; a push into a full FIFO is accepted only alongside a pop.
  always_comb begin
    pop_ok   = pop_i && !empty_q;
    push_ok  = push_i && (!full || pop_ok);
    wr_ptr_d = push_ok ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop_ok  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    count_d  = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    empty_d = (count_d == '0);
    // The head is registered, so it is looked up from next-state pointers; when the
    // new head is the word being written this edge it bypasses the memory.
    head_d = head_q;
    if ((push_ok || pop_ok) && !empty_d) begin
      head_d = (push_ok && (wr_ptr_q == rd_ptr_d)) ? push_data_i : mem_q[rd_ptr_d];
    end
  end

  // Pointer, count and head registers; reset discards all contents.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      empty_q  <= empty_d;
    end
  end

  // Storage array; no reset needed since the pointers gate every read.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/ftdi_sync_rx.sv
// FT232H 245 synchronous FIFO receive path: drives OE#/RD#, buffers host bytes, streams them out.
module ftdi_sync_rx
  import ftdi_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned HEADROOM   = 3
) (
  input  logic                   ftdiclk,
  input  logic                   reset,
  input  logic                   ftdi_rxf_n,
  input  logic [FTDI_BYTE_W-1:0] ftdi_data_in,
  output logic                   ftdi_oe_n,
  output logic                   ftdi_rd_n,
  output logic                   rx_bus_owned,
  output logic [FTDI_BYTE_W-1:0] m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   overflow,
  output logic [15:0]            rx_count
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C    = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] HEADROOM_C = CW'(HEADROOM);

  rx_state_t        state_q, state_d;
  logic             oe_n_q, oe_n_d;
  logic             rd_n_q, rd_n_d;
  logic             owned_q, owned_d;
  logic             overflow_q, overflow_d;
  logic [15:0]      rx_count_q, rx_count_d;

  logic [CW-1:0]    fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CW-1:0]    space;
  logic             has_room;
  logic             rxf;
  logic             capture;
  logic             pop;
  logic             push_acc;

  assign space    = DEPTH_C - fifo_count;
  assign has_room = (space >= HEADROOM_C);
  assign rxf      = (ftdi_rxf_n == FTDI_ASSERTED);

  assign ftdi_oe_n    = oe_n_q;
  assign ftdi_rd_n    = rd_n_q;
  assign rx_bus_owned = owned_q;
  assign m_valid      = !fifo_empty;
  assign overflow     = overflow_q;
  assign rx_count     = rx_count_q;

  // Next-state logic; pin levels are derived from the next state so they register with it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (rxf && has_room) state_d = OE_SETUP;
      OE_SETUP: state_d = rxf ? READ : RELEASE;
      READ:     if (!(rxf && has_room)) state_d = RELEASE;
      RELEASE:  state_d = IDLE;
      default:  state_d = IDLE;
    endcase

    oe_n_d  = FTDI_DEASSERTED;
    rd_n_d  = FTDI_DEASSERTED;
    owned_d = 1'b0;
    case (state_d)
      OE_SETUP: begin
        oe_n_d  = FTDI_ASSERTED;
        owned_d = 1'b1;
      end
      READ: begin
        oe_n_d  = FTDI_ASSERTED;
        rd_n_d  = FTDI_ASSERTED;
        owned_d = 1'b1;
      end
      RELEASE:  owned_d = 1'b1;
      default:  owned_d = 1'b0;
    endcase
  end

  // State and pin registers.
  always_ff @(posedge ftdiclk) begin
    if (reset) begin
      state_q <= IDLE;
      oe_n_q  <= FTDI_DEASSERTED;
      rd_n_q  <= FTDI_DEASSERTED;
      owned_q <= 1'b0;
    end else begin
      state_q <= state_d;
      oe_n_q  <= oe_n_d;
      rd_n_q  <= rd_n_d;
      owned_q <= owned_d;
    end
  end

  // A byte is valid when RD# was low going into the edge and RXF# is still low at it.
  always_comb begin
    capture    = (rd_n_q == FTDI_ASSERTED) && rxf;
    pop        = !fifo_empty && m_ready;
    push_acc   = capture && (!fifo_full || pop);
    rx_count_d = rx_count_q + 16'(push_acc);
    overflow_d = overflow_q || (capture && fifo_full && !pop);
  end

  // Sticky overflow flag and accepted-byte counter.
  always_ff @(posedge ftdiclk) begin
    if (reset) begin
      overflow_q <= 1'b0;
      rx_count_q <= '0;
    end else begin
      overflow_q <= overflow_d;
      rx_count_q <= rx_count_d;
    end
  end

  byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FTDI_BYTE_W)
  ) u_fifo (
    .clk_i       (ftdiclk),
    .rst_i       (reset),
    .push_i      (capture),
    .push_data_i (ftdi_data_in),
    .pop_i       (pop),
    .head_data_o (m_data),
    .count_o     (fifo_count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

endmodule

// File: tb/tb_ftdi_sync_rx.sv
// Self-checking bench for ftdi_sync_rx: an FTDI host-FIFO model feeds bytes, a stream sink collects them.
module tb_ftdi_sync_rx;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned HR    = 3;
  localparam int          NBIG  = 70000;

  logic       ftdiclk = 1'b0;
  logic       reset;
  logic       ftdi_rxf_n;
  logic [7:0] ftdi_data_in;
  logic       ftdi_oe_n;
  logic       ftdi_rd_n;
  logic       rx_bus_owned;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       overflow;
  logic [15:0] rx_count;

  int tests_run    = 0;
  int tests_failed = 0;
  int cycle_no     = 0;
  int stall_viol   = 0;
  int ready_mode   = 0;   // 0: never ready, 1: always ready, 2: random

  logic [7:0] host_q[$];  // bytes still waiting inside the FTDI
  logic [7:0] got_q[$];   // bytes taken from the stream

  always #8 ftdiclk = ~ftdiclk;

  ftdi_sync_rx #(
    .FIFO_DEPTH (DEPTH),
    .HEADROOM   (HR)
  ) dut (
    .ftdiclk      (ftdiclk),
    .reset        (reset),
    .ftdi_rxf_n   (ftdi_rxf_n),
    .ftdi_data_in (ftdi_data_in),
    .ftdi_oe_n    (ftdi_oe_n),
    .ftdi_rd_n    (ftdi_rd_n),
    .rx_bus_owned (rx_bus_owned),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .overflow     (overflow),
    .rx_count     (rx_count)
  );

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, got %0d cycles, required completion", cycle_no);
    $fatal(1);
  end

  // FTDI pins and sink ready, updated just after each edge.
  task automatic drive();
    ftdi_rxf_n   = (host_q.size() == 0);
    ftdi_data_in = (ftdi_oe_n === 1'b0 && host_q.size() != 0) ? host_q[0] : 8'($urandom);
    case (ready_mode)
      0:       m_ready = 1'b0;
      1:       m_ready = 1'b1;
      default: m_ready = ($urandom_range(31) != 0);
    endcase
  endtask

  // One clock: the FTDI hands over its head byte when RD# and RXF# are both low at the edge.
  task automatic step();
    logic cap, xfer, stall;
    logic [7:0] xd;
    cap   = !reset && ftdi_rd_n === 1'b0 && ftdi_rxf_n === 1'b0;
    xfer  = !reset && m_valid === 1'b1 && m_ready === 1'b1;
    stall = !reset && m_valid === 1'b1 && m_ready === 1'b0;
    xd    = m_data;
    @(posedge ftdiclk);
    #1;
    cycle_no++;
    if (cap && host_q.size() != 0) void'(host_q.pop_front());
    if (xfer) got_q.push_back(xd);
    if (stall && (m_valid !== 1'b1 || m_data !== xd)) stall_viol++;
    drive();
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    host_q.delete();
    drive();
    repeat (3) step();
    reset = 1'b0;
    got_q.delete();
    stall_viol = 0;
  endtask

  // Index of the first difference between two byte lists, -1 if identical.
  function automatic int first_diff(input logic [7:0] a[$], input logic [7:0] b[$]);
    int n;
    n = (a.size() < b.size()) ? a.size() : b.size();
    for (int i = 0; i < n; i++) if (a[i] !== b[i]) return i;
    if (a.size() != b.size()) return n;
    return -1;
  endfunction

  task automatic test_reset();
    int bad;
    ready_mode = 1;
    apply_reset();
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (ftdi_oe_n !== 1'b1 || ftdi_rd_n !== 1'b1 || rx_bus_owned !== 1'b0 || m_valid !== 1'b0) bad++;
    end
    tests_run++;
    if (bad !== 0) begin tests_failed++; $display("FAIL reset_idle_pins: %0d bad cycles, required 0", bad); end
    tests_run++;
    if (ftdi_oe_n !== 1'b1) begin tests_failed++; $display("FAIL reset_oe_n: got %b, required 1", ftdi_oe_n); end
    tests_run++;
    if (ftdi_rd_n !== 1'b1) begin tests_failed++; $display("FAIL reset_rd_n: got %b, required 1", ftdi_rd_n); end
    tests_run++;
    if (rx_bus_owned !== 1'b0) begin tests_failed++; $display("FAIL reset_owned: got %b, required 0", rx_bus_owned); end
    tests_run++;
    if (m_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_m_valid: got %b, required 0", m_valid); end
    tests_run++;
    if (m_data !== 8'h00) begin tests_failed++; $display("FAIL reset_m_data: got %h, required 00", m_data); end
    tests_run++;
    if (rx_count !== 16'd0) begin tests_failed++; $display("FAIL reset_rx_count: got %0d, required 0", rx_count); end
    tests_run++;
    if (overflow !== 1'b0) begin tests_failed++; $display("FAIL reset_overflow: got %b, required 0", overflow); end
  endtask

  task automatic test_basic_burst();
    logic [7:0] sent[$];
    int start, oe_cyc, rd_cyc, d;
    logic first_mv, release_seen;
    logic [7:0] first_md;
    ready_mode = 1;
    apply_reset();
    sent = '{8'h45, 8'h46, 8'h47};
    host_q = sent;
    drive();                       // RXF# falls here
    start = cycle_no;
    oe_cyc = -1; rd_cyc = -1;
    first_mv = 1'b0; first_md = 8'h00; release_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (oe_cyc < 0 && ftdi_oe_n === 1'b0) oe_cyc = cycle_no;
      if (rd_cyc < 0 && ftdi_rd_n === 1'b0) rd_cyc = cycle_no;
      if (rd_cyc >= 0 && cycle_no == rd_cyc + 1) begin first_mv = m_valid; first_md = m_data; end
      if (ftdi_oe_n === 1'b1 && ftdi_rd_n === 1'b1 && rx_bus_owned === 1'b1) release_seen = 1'b1;
    end
    tests_run++;
    if (oe_cyc - start != 1) begin tests_failed++; $display("FAIL basic_oe_latency: got %0d cycles, required 1", oe_cyc - start); end
    tests_run++;
    if (rd_cyc - start != 2) begin tests_failed++; $display("FAIL basic_rd_latency: got %0d cycles, required 2", rd_cyc - start); end
    tests_run++;
    if (first_mv !== 1'b1 || first_md !== 8'h45) begin
      tests_failed++; $display("FAIL basic_first_byte: got valid=%b data=%h, required valid=1 data=45", first_mv, first_md);
    end
    d = first_diff(got_q, sent);
    tests_run++;
    if (d >= 0) begin tests_failed++; $display("FAIL basic_stream: %0d bytes, first diff at %0d, required %0d bytes 45 46 47", got_q.size(), d, sent.size()); end
    tests_run++;
    if (rx_count !== 16'd3) begin tests_failed++; $display("FAIL basic_rx_count: got %0d, required 3", rx_count); end
    tests_run++;
    if (release_seen !== 1'b1) begin tests_failed++; $display("FAIL basic_release: got %b, required 1", release_seen); end
    tests_run++;
    if (overflow !== 1'b0 || rx_bus_owned !== 1'b0) begin
      tests_failed++; $display("FAIL basic_end_state: got overflow=%b owned=%b, required 0 0", overflow, rx_bus_owned);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] sent[$];
    int fill, d, n;
    ready_mode = 0;
    apply_reset();
    for (int i = 0; i < 20; i++) sent.push_back(8'(i));
    host_q = sent;
    drive();
    repeat (40) step();
    // READ is kept while space >= HEADROOM before the edge and the leaving edge still
    // takes its byte, so the burst stops with DEPTH - HEADROOM + 2 bytes held.
    fill = int'(DEPTH) - int'(HR) + 2;
    tests_run++;
    if (ftdi_rd_n !== 1'b1 || rx_bus_owned !== 1'b0) begin
      tests_failed++; $display("FAIL bp_paused: got rd_n=%b owned=%b, required 1 0", ftdi_rd_n, rx_bus_owned);
    end
    tests_run++;
    if (rx_count !== 16'(fill)) begin tests_failed++; $display("FAIL bp_fill: got %0d, required %0d", rx_count, fill); end
    tests_run++;
    if (m_valid !== 1'b1 || m_data !== 8'h00) begin
      tests_failed++; $display("FAIL bp_head_held: got valid=%b data=%h, required 1 00", m_valid, m_data);
    end
    ready_mode = 1;
    n = 0;
    while (got_q.size() < sent.size() && n < 300) begin step(); n++; end
    tests_run++;
    if (n >= 300) begin tests_failed++; $display("FAIL bp_timeout: got %0d bytes, required %0d", got_q.size(), sent.size()); end
    d = first_diff(got_q, sent);
    tests_run++;
    if (d >= 0) begin tests_failed++; $display("FAIL bp_stream: first diff at %0d, got %0d bytes, required %0d", d, got_q.size(), sent.size()); end
    tests_run++;
    if (rx_count !== 16'd20) begin tests_failed++; $display("FAIL bp_rx_count: got %0d, required 20", rx_count); end
    tests_run++;
    if (overflow !== 1'b0 || stall_viol != 0) begin
      tests_failed++; $display("FAIL bp_clean: got overflow=%b stall_changes=%0d, required 0 0", overflow, stall_viol);
    end
  endtask

  task automatic test_early_stop();
    logic [7:0] sent[$];
    int n, d;
    ready_mode = 1;
    apply_reset();
    sent = '{8'hA0, 8'hA1};
    host_q = sent;
    drive();
    n = 0;
    while (host_q.size() != 0 && n < 20) begin step(); n++; end
    tests_run++;
    if (n >= 20) begin tests_failed++; $display("FAIL early_timeout: got %0d left in host, required 0", host_q.size()); end
    // RXF# has just risen while RD# is low.
    step();
    tests_run++;
    if (ftdi_oe_n !== 1'b1 || ftdi_rd_n !== 1'b1 || rx_bus_owned !== 1'b1) begin
      tests_failed++; $display("FAIL early_release: got oe=%b rd=%b owned=%b, required 1 1 1", ftdi_oe_n, ftdi_rd_n, rx_bus_owned);
    end
    step();
    tests_run++;
    if (rx_bus_owned !== 1'b0 || ftdi_oe_n !== 1'b1) begin
      tests_failed++; $display("FAIL early_idle: got owned=%b oe=%b, required 0 1", rx_bus_owned, ftdi_oe_n);
    end
    repeat (5) step();
    tests_run++;
    if (rx_count !== 16'd2) begin tests_failed++; $display("FAIL early_rx_count: got %0d, required 2", rx_count); end
    d = first_diff(got_q, sent);
    tests_run++;
    if (d >= 0) begin tests_failed++; $display("FAIL early_stream: got %0d bytes, required a0 a1", got_q.size()); end
  endtask

  task automatic test_reset_mid_burst();
    logic [7:0] remaining[$];
    int n, d;
    ready_mode = 0;
    apply_reset();
    for (int i = 0; i < 10; i++) host_q.push_back(8'($urandom));
    drive();
    n = 0;
    while (rx_count !== 16'd4 && n < 20) begin step(); n++; end
    tests_run++;
    if (ftdi_rd_n !== 1'b0 || rx_count !== 16'd4) begin
      tests_failed++; $display("FAIL mid_in_read: got rd_n=%b count=%0d, required 0 4", ftdi_rd_n, rx_count);
    end
    remaining = host_q;
    reset = 1'b1;
    step();
    tests_run++;
    if (ftdi_oe_n !== 1'b1 || ftdi_rd_n !== 1'b1 || rx_bus_owned !== 1'b0) begin
      tests_failed++; $display("FAIL mid_pins: got oe=%b rd=%b owned=%b, required 1 1 0", ftdi_oe_n, ftdi_rd_n, rx_bus_owned);
    end
    tests_run++;
    if (m_valid !== 1'b0 || m_data !== 8'h00) begin
      tests_failed++; $display("FAIL mid_stream: got valid=%b data=%h, required 0 00", m_valid, m_data);
    end
    tests_run++;
    if (rx_count !== 16'd0) begin tests_failed++; $display("FAIL mid_rx_count: got %0d, required 0", rx_count); end
    reset = 1'b0;
    got_q.delete();
    ready_mode = 1;
    drive();
    n = 0;
    while (got_q.size() < remaining.size() && n < 100) begin step(); n++; end
    d = first_diff(got_q, remaining);
    tests_run++;
    if (d >= 0) begin tests_failed++; $display("FAIL mid_restart_stream: first diff at %0d, got %0d bytes, required %0d", d, got_q.size(), remaining.size()); end
    tests_run++;
    if (rx_count !== 16'(remaining.size())) begin
      tests_failed++; $display("FAIL mid_restart_count: got %0d, required %0d", rx_count, remaining.size());
    end
  endtask

  task automatic test_long_random();
    logic [7:0] sent[$];
    int n, d;
    ready_mode = 2;
    apply_reset();
    for (int i = 0; i < NBIG; i++) sent.push_back(8'($urandom));
    host_q = sent;
    drive();
    n = 0;
    while (got_q.size() < sent.size() && n < 90000) begin step(); n++; end
    tests_run++;
    if (n >= 90000) begin tests_failed++; $display("FAIL long_timeout: got %0d bytes, required %0d", got_q.size(), NBIG); end
    d = first_diff(got_q, sent);
    tests_run++;
    if (d >= 0) begin
      tests_failed++; $display("FAIL long_stream: first diff at %0d, got %0d bytes, required %0d", d, got_q.size(), NBIG);
    end
    tests_run++;
    if (rx_count !== 16'(NBIG % 65536)) begin
      tests_failed++; $display("FAIL long_rx_count: got %0d, required %0d", rx_count, NBIG % 65536);
    end
    tests_run++;
    if (overflow !== 1'b0) begin tests_failed++; $display("FAIL long_overflow: got %b, required 0", overflow); end
    tests_run++;
    if (stall_viol != 0) begin tests_failed++; $display("FAIL long_stall_stable: got %0d changes, required 0", stall_viol); end
  endtask

  initial begin
    reset        = 1'b1;
    ftdi_rxf_n   = 1'b1;
    ftdi_data_in = 8'h00;
    m_ready      = 1'b0;
    test_reset();
    test_basic_burst();
    test_backpressure();
    test_early_stop();
    test_reset_mid_burst();
    test_long_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ftdi_sync_rx.md
Name: ftdi_sync_rx

Overview:
- Receive path for the FT232H in 245 synchronous FIFO mode: moves host-to-FPGA bytes from the FTDI FIFO into an on-chip byte stream.
- Drives OE#/RD# from RXF#, captures ftdi data into a small internal FIFO, and presents bytes on a valid/ready stream.
- Sits alongside the transmit logic in the ftdiclk domain. The top level owns the ftdi_data tristate and arbitrates TX vs RX using rx_bus_owned.

Parameters:
- FIFO_DEPTH, 8, internal byte FIFO depth; power of two, >= 4.
- HEADROOM, 3, free entries required to start or continue a read burst; 2 <= HEADROOM < FIFO_DEPTH.

Ports:
- ftdiclk  input  1  60 MHz FTDI clock; the only clock.
- reset  input  1  synchronous, active-high (from reset_sync).
- ftdi_rxf_n  input  1  low = FTDI has host data.
- ftdi_data_in  input  8  ftdi_data bus as sampled at the pins.
- ftdi_oe_n  output  1  FTDI output enable, active-low.
- ftdi_rd_n  output  1  FTDI read strobe, active-low.
- rx_bus_owned  output  1  high = FTDI may drive the bus; top must tristate FPGA drivers.
- m_data  output  8  stream byte.
- m_valid  output  1  stream valid.
- m_ready  input  1  stream ready.
- overflow  output  1  sticky: a byte was dropped because the FIFO was full.
- rx_count  output  16  bytes accepted into the FIFO, wraps modulo 2^16.

Behaviour:
- Single clock domain; all outputs registered.
- Reset values: ftdi_oe_n=1, ftdi_rd_n=1, rx_bus_owned=0, m_valid=0, m_data=0, overflow=0, rx_count=0, FIFO empty, state IDLE.
- Reset asserted mid-burst: on the next edge, OE# and RD# are 1 and FIFO contents are discarded.
- space = FIFO_DEPTH - fifo_count, evaluated combinationally from the current count.
- State machine (state register, outputs registered with state):
  - IDLE: oe_n=1, rd_n=1, rx_bus_owned=0. Go to OE_SETUP when ftdi_rxf_n==0 and space >= HEADROOM.
  - OE_SETUP: oe_n=0, rd_n=1, rx_bus_owned=1. Exactly one cycle, giving the FTDI one cycle of bus turnaround. Then READ if ftdi_rxf_n==0, else RELEASE.
  - READ: oe_n=0, rd_n=0, rx_bus_owned=1. Stay while ftdi_rxf_n==0 and space >= HEADROOM. Otherwise go to RELEASE.
  - RELEASE: oe_n=1, rd_n=1, rx_bus_owned=1. One cycle for the FTDI to release the bus, then IDLE.
- Capture rule: on a rising edge where the registered ftdi_rd_n==0 and the sampled ftdi_rxf_n==0, ftdi_data_in is a valid byte.
  - Write the byte into the FIFO and increment rx_count.
  - If the FIFO is full that cycle, drop the byte, set overflow, and leave rx_count unchanged. overflow cannot occur when HEADROOM >= 2 and the downstream is otherwise idle.
- RXF# rising while RD# is low: the byte on that edge is not captured; the FSM leaves READ on the same edge.
- Stream output:
  - FIFO head is presented with first-word-fall-through.
  - m_valid=1 whenever the FIFO is non-empty.
  - A transfer occurs on an edge where m_valid && m_ready; the FIFO pops on that edge.
  - m_data and m_valid must not change while m_valid && !m_ready.
- Simultaneous push and pop: both take effect; the count is unchanged. Push into a full FIFO with a simultaneous pop is accepted (not an overflow).
- Latency: 2 cycles from RXF# falling to the first RD#-low cycle. The first byte reaches m_valid 1 cycle after its capture edge.
- Back-to-back bursts: at least 2 cycles (RELEASE, IDLE) separate a burst end from the next OE_SETUP.

Decomposition:
- ftdi_pkg holds:
  - rx_state_t enum: IDLE, OE_SETUP, READ, RELEASE.
  - Shared FTDI constants: byte width 8, active-low asserted/deasserted levels.
  - Later, the tx state enum.
- One sub-module: byte_fifo, a synchronous first-word-fall-through FIFO with parameter DEPTH and ports push, push_data, pop, head_data, count, full, empty.

Test Plan:
- Reset then hold RXF#=1 for 20 cycles -> OE#=RD#=1, rx_bus_owned=0, m_valid=0, rx_count=0.
- Model presents 0x45,0x46,0x47 with m_ready=1 -> OE# low 1 cycle before RD#; stream emits 0x45,0x46,0x47 in order; rx_count=3; RELEASE seen; overflow=0.
- Model has 20 bytes (0x00..0x13) with m_ready=0 -> RD# deasserts when space < 3; no drop, overflow=0. Then raise m_ready=1 -> bursts resume; all 20 bytes delivered in order; rx_count=20.
- RXF# rises after 2 bytes of a burst -> exactly 2 bytes captured; FSM goes READ->RELEASE->IDLE; rx_bus_owned falls 2 cycles after RXF# rises.
- Assert reset while in READ with 4 bytes queued -> next edge OE#=RD#=1, m_valid=0, rx_count=0; clean restart afterwards.
- Run 70000 bytes with random m_ready -> rx_count wraps to 70000 mod 65536 = 4464; stream data matches the model's byte sequence.
